regfile_wb_ctrl: RTL and testbench

- Write-port controller in front of the banked per-thread register file, in the writeback stage.
- Registers writeback traffic from the barrel pipeline and suppresses writes to x0.
- After reset, sweeps every register-file entry of every thread to zero; until done, holds the core in stall through o_init_done.
- In normal operation, zeroes a single thread's 32 registers on request, using only idle write-port cycles.

---
 rtl/regfile_wb_ctrl.sv | 160 ++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Writeback-stage write-port controller for the banked per-thread register file.
// Performs the post-reset zero sweep, x0 suppression and idle-slot thread clears.
package riscv_pkg;
    localparam int NUM_THREADS = 16;
endpackage

module regfile_wb_ctrl #(
    parameter int DWIDTH      = 32,
    parameter int NUM_THREADS = riscv_pkg::NUM_THREADS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wb_valid,
    input  logic                           i_wb_we,
    input  logic [$clog2(NUM_THREADS)-1:0] i_wb_thread,
    input  logic [4:0]                     i_wb_rd,
    input  logic [DWIDTH-1:0]              i_wb_data,
    input  logic                           i_thr_clr_req,
    input  logic [$clog2(NUM_THREADS)-1:0] i_thr_clr_idx,
    output logic                           o_rf_wr_en,
    output logic [$clog2(NUM_THREADS)-1:0] o_rf_thread,
    output logic [4:0]                     o_rf_addr,
    output logic [DWIDTH-1:0]              o_rf_data,
    output logic                           o_init_done,
    output logic                           o_thr_clr_busy,
    output logic                           o_wb_drop
);

    localparam int RF_SIZE = NUM_THREADS * 32;
    localparam int TW      = $clog2(NUM_THREADS);
    localparam int CW      = $clog2(RF_SIZE);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_TCLR
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     sweep_q, sweep_d;
    logic [4:0]        clr_cnt_q, clr_cnt_d;
    logic [TW-1:0]     clr_thr_q, clr_thr_d;
    logic              wr_en_q, wr_en_d;
    logic [TW-1:0]     thread_q, thread_d;
    logic [4:0]        addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic              wb_wr;
    logic              wb_qual;

    assign wb_wr   = i_wb_valid & i_wb_we;
    assign wb_qual = wb_wr & (i_wb_rd != 5'd0);

    // Next-state and registered-output selection; outputs hold unless written.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        clr_cnt_d = clr_cnt_q;
        clr_thr_d = clr_thr_q;
        wr_en_d   = 1'b0;
        thread_d  = thread_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q | (state_q != S_INIT);
        busy_d    = 1'b0;
        drop_d    = drop_q;
        unique case (state_q)
            S_INIT: begin
                wr_en_d             = 1'b1;
                {thread_d, addr_d}  = sweep_q;
                data_d              = '0;
                sweep_d             = sweep_q + 1'b1;
                if (wb_wr) begin
                    drop_d = 1'b1;
                end
                if (sweep_q == CW'(RF_SIZE - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wb_qual) begin
                    wr_en_d  = 1'b1;
                    thread_d = i_wb_thread;
                    addr_d   = i_wb_rd;
                    data_d   = i_wb_data;
                end
                if (i_thr_clr_req) begin
                    clr_thr_d = i_thr_clr_idx;
                    clr_cnt_d = '0;
                    state_d   = S_TCLR;
                    busy_d    = 1'b1;
                end
            end
            S_TCLR: begin
                busy_d = 1'b1;
                if (wb_qual && (i_wb_thread != clr_thr_q)) begin
                    wr_en_d  = 1'b1;
                    thread_d = i_wb_thread;
                    addr_d   = i_wb_rd;
                    data_d   = i_wb_data;
                end else begin
                    if (wb_qual) begin
                        drop_d = 1'b1;
                    end
                    wr_en_d   = 1'b1;
                    thread_d  = clr_thr_q;
                    addr_d    = clr_cnt_q;
                    data_d    = '0;
                    clr_cnt_d = clr_cnt_q + 5'd1;
                    if (clr_cnt_q == 5'd31) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            sweep_q   <= '0;
            clr_cnt_q <= '0;
            clr_thr_q <= '0;
            wr_en_q   <= 1'b0;
            thread_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            clr_cnt_q <= clr_cnt_d;
            clr_thr_q <= clr_thr_d;
            wr_en_q   <= wr_en_d;
            thread_q  <= thread_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign o_rf_wr_en     = wr_en_q;
    assign o_rf_thread    = thread_q;
    assign o_rf_addr      = addr_q;
    assign o_rf_data      = data_q;
    assign o_init_done    = done_q;
    assign o_thr_clr_busy = busy_q;
    assign o_wb_drop      = drop_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: a cycle-level reference model
// predicts every output cycle, a monitor compares one cycle later.
module tb_regfile_wb_ctrl;

    localparam int NT = 16;
    localparam int RF = NT * 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_thread = '0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        clr_req = 1'b0;
    logic [3:0]  clr_idx = '0;
    logic        rf_wr_en;
    logic [3:0]  rf_thread;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        init_done;
    logic        clr_busy;
    logic        wb_drop;

    regfile_wb_ctrl #(.DWIDTH(32), .NUM_THREADS(NT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wb_valid     (wb_valid),
        .i_wb_we        (wb_we),
        .i_wb_thread    (wb_thread),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .i_thr_clr_req  (clr_req),
        .i_thr_clr_idx  (clr_idx),
        .o_rf_wr_en     (rf_wr_en),
        .o_rf_thread    (rf_thread),
        .o_rf_addr      (rf_addr),
        .o_rf_data      (rf_data),
        .o_init_done    (init_done),
        .o_thr_clr_busy (clr_busy),
        .o_wb_drop      (wb_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [3:0]  thr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        done;
        logic        busy;
        logic        drop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit   m_init;
    int   m_sweep;
    int   m_thr;
    int   m_clr[$];
    exp_t m_out;

    task automatic model_reset();
        m_init  = 1'b1;
        m_sweep = 0;
        m_thr   = 0;
        m_clr.delete();
        m_out   = '0;
    endtask

    task automatic model_step();
        exp_t n;
        bit   clearing;
        bit   qual;
        n        = m_out;
        n.wr     = 1'b0;
        n.busy   = 1'b0;
        n.done   = m_out.done | !m_init;
        clearing = (m_clr.size() > 0);
        qual     = wb_valid && wb_we && (wb_rd != 0);
        if (m_init) begin
            n.wr   = 1'b1;
            n.thr  = 4'(m_sweep / 32);
            n.addr = 5'(m_sweep % 32);
            n.data = '0;
            if (wb_valid && wb_we) n.drop = 1'b1;
            m_sweep++;
            if (m_sweep == RF) m_init = 1'b0;
        end else if (clearing) begin
            n.busy = 1'b1;
            if (qual && (int'(wb_thread) != m_thr)) begin
                n.wr = 1'b1; n.thr = wb_thread;
                n.addr = wb_rd; n.data = wb_data;
            end else begin
                if (qual) n.drop = 1'b1;
                n.wr   = 1'b1;
                n.thr  = 4'(m_thr);
                n.addr = 5'(m_clr.pop_front());
                n.data = '0;
            end
        end else begin
            if (qual) begin
                n.wr = 1'b1; n.thr = wb_thread;
                n.addr = wb_rd; n.data = wb_data;
            end
            if (clr_req) begin
                m_thr  = int'(clr_idx);
                for (int i = 0; i < 32; i++) m_clr.push_back(i);
                n.busy = 1'b1;
            end
        end
        m_out = n;
        sb.push_back(n);
    endtask

    // drive one cycle of inputs at a negedge, predict, advance
    task automatic step(input bit v, input bit we, input int t,
                        input int rd, input logic [31:0] d,
                        input bit rq, input int ix);
        wb_valid  = v;
        wb_we     = we;
        wb_thread = 4'(t);
        wb_rd     = 5'(rd);
        wb_data   = d;
        clr_req   = rq;
        clr_idx   = 4'(ix);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        exp_t a;
        rst_n = 1'b0;
        sb.delete();
        #1;
        a = {rf_wr_en, rf_thread, rf_addr, rf_data,
             init_done, clr_busy, wb_drop};
        checks++;
        if (a !== exp_t'(0)) begin
            errors++;
            $display("FAIL reset_zero got %h want 0", a);
        end
        repeat (2) @(negedge clk);
        wb_valid = 0; wb_we = 0; clr_req = 0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            int rd;
            rd = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 int'($urandom_range(0, NT - 1)), rd, $urandom,
                 $urandom_range(0, 40) == 0, int'($urandom_range(0, NT - 1)));
        end
    endtask

    // monitor: compare the DUT outputs against the oldest prediction
    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            a = {rf_wr_en, rf_thread, rf_addr, rf_data,
                 init_done, clr_busy, wb_drop};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out t=%0t got wr=%b thr=%0d addr=%0d data=%h done=%b busy=%b drop=%b want wr=%b thr=%0d addr=%0d data=%h done=%b busy=%b drop=%b",
                         $time, a.wr, a.thr, a.addr, a.data, a.done, a.busy, a.drop,
                         e.wr, e.thr, e.addr, e.data, e.done, e.busy, e.drop);
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        idle(RF + 4);
        step(1, 1, 3, 5, 32'hDEADBEEF, 0, 0);
        step(1, 1, 3, 0, 32'hDEADBEEF, 0, 0);
        idle(2);
        step(0, 0, 0, 0, '0, 1, 7);
        idle(36);
        step(0, 0, 0, 0, '0, 1, 7);
        for (int i = 0; i < 70; i++) begin
            if (i == 21)
                step(1, 1, 7, 9, $urandom, 0, 0);
            else if (i % 2 == 0)
                step(1, 1, 2, (i % 31) + 1, $urandom, 0, 0);
            else
                idle(1);
        end
        idle(4);
        rand_phase(3000);
        idle(40);
        step(0, 0, 0, 0, '0, 1, 7);
        idle(14);
        do_reset();
        for (int i = 0; i < RF + 4; i++) begin
            if (i == 10) step(1, 1, 4, 6, 32'h1234, 0, 0);
            else idle(1);
        end
        rand_phase(800);
        idle(40);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
